// File: rtl/tl_ul_channel_buffer.sv
// Registered TileLink-UL A/D channel buffer with outstanding-request tracking and idle reporting.
// Optional same-cycle bypass of an empty FIFO when TL_BUF_FLOW_EN is defined.

module tl_ul_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_bits,
  input  logic                       allow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_bits,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  storage [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          in_fire;
  logic          push;
  logic          pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  // allow is derived from registered state only, so in_ready never depends on out_ready.
  assign in_ready = !full && allow;
  assign in_fire  = in_valid && in_ready;
  assign pop      = !empty && out_ready;

`ifdef TL_BUF_FLOW_EN
  logic bypass;
  // Gating with in_ready keeps a beat the input refuses from also appearing at the output.
  assign bypass    = empty && in_fire;
  assign out_valid = !empty || bypass;
  assign out_bits  = bypass ? in_bits : storage[rd_ptr];
  assign push      = in_fire && !(bypass && out_ready);
`else
  assign out_valid = !empty;
  assign out_bits  = storage[rd_ptr];
  assign push      = in_fire;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
    end else begin
      if (push) begin
        storage[wr_ptr] <= in_bits;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

module tl_ul_channel_buffer #(
  parameter int A_DEPTH      = 2,
  parameter int D_DEPTH      = 2,
  parameter int SIZE_W       = 2,
  parameter int SRC_W        = 1,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_a_valid,
  output logic                              in_a_ready,
  input  logic [75+SIZE_W+SRC_W-1:0]        in_a_bits,
  output logic                              out_a_valid,
  input  logic                              out_a_ready,
  output logic [75+SIZE_W+SRC_W-1:0]        out_a_bits,
  input  logic                              in_d_valid,
  output logic                              in_d_ready,
  input  logic [39+SIZE_W+SRC_W-1:0]        in_d_bits,
  output logic                              out_d_valid,
  input  logic                              out_d_ready,
  output logic [39+SIZE_W+SRC_W-1:0]        out_d_bits,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              idle
);

  localparam int AW = 75 + SIZE_W + SRC_W;
  localparam int DW = 39 + SIZE_W + SRC_W;
  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  logic [$clog2(A_DEPTH):0] a_count;
  logic [$clog2(D_DEPTH):0] d_count;
  logic                     a_allow;
  logic                     a_out_fire;
  logic                     d_out_fire;

  // Requests still queued count against the limit so a full pipe cannot overshoot it.
  assign a_allow    = (32'(inflight) + 32'(a_count)) < 32'(MAX_INFLIGHT);
  assign a_out_fire = out_a_valid && out_a_ready;
  assign d_out_fire = out_d_valid && out_d_ready;
  assign idle       = (inflight == '0) && (a_count == '0) && (d_count == '0);

  tl_ul_fifo #(.DEPTH(A_DEPTH), .W(AW)) u_a_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_a_valid),
    .in_ready  (in_a_ready),
    .in_bits   (in_a_bits),
    .allow     (a_allow),
    .out_valid (out_a_valid),
    .out_ready (out_a_ready),
    .out_bits  (out_a_bits),
    .count     (a_count)
  );

  tl_ul_fifo #(.DEPTH(D_DEPTH), .W(DW)) u_d_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_d_valid),
    .in_ready  (in_d_ready),
    .in_bits   (in_d_bits),
    .allow     (1'b1),
    .out_valid (out_d_valid),
    .out_ready (out_d_ready),
    .out_bits  (out_d_bits),
    .count     (d_count)
  );

  // A response with nothing outstanding is still forwarded; the counter just holds at zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
    end else if (a_out_fire && !d_out_fire) begin
      inflight <= inflight + IW'(1);
    end else if (d_out_fire && !a_out_fire && (inflight != '0)) begin
      inflight <= inflight - IW'(1);
    end
  end

endmodule

// File: tb/tb_tl_ul_channel_buffer.sv
// Scoreboarded bench for tl_ul_channel_buffer: per-scenario tasks plus a negedge monitor.
// Default build expects registered latency; TL_BUF_FLOW_EN build expects same-cycle bypass.

module tb_tl_ul_channel_buffer;

  localparam int SIZE_W = 2;
  localparam int SRC_W  = 1;
  localparam int AW     = 75 + SIZE_W + SRC_W;
  localparam int DW     = 39 + SIZE_W + SRC_W;
  localparam int IW     = 3;

  logic          clock;
  logic          reset;
  logic          in_a_valid;
  logic          in_a_ready;
  logic [AW-1:0] in_a_bits;
  logic          out_a_valid;
  logic          out_a_ready;
  logic [AW-1:0] out_a_bits;
  logic          in_d_valid;
  logic          in_d_ready;
  logic [DW-1:0] in_d_bits;
  logic          out_d_valid;
  logic          out_d_ready;
  logic [DW-1:0] out_d_bits;
  logic [IW-1:0] inflight;
  logic          idle;

  int vectors;
  int miscompares;

  logic [AW-1:0] a_q[$];
  logic [DW-1:0] d_q[$];

  tl_ul_channel_buffer #(
    .A_DEPTH(2), .D_DEPTH(2), .SIZE_W(SIZE_W), .SRC_W(SRC_W), .MAX_INFLIGHT(4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_a_valid  (in_a_valid),
    .in_a_ready  (in_a_ready),
    .in_a_bits   (in_a_bits),
    .out_a_valid (out_a_valid),
    .out_a_ready (out_a_ready),
    .out_a_bits  (out_a_bits),
    .in_d_valid  (in_d_valid),
    .in_d_ready  (in_d_ready),
    .in_d_bits   (in_d_bits),
    .out_d_valid (out_d_valid),
    .out_d_ready (out_d_ready),
    .out_d_bits  (out_d_bits),
    .inflight    (inflight),
    .idle        (idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [AW-1:0] a_get(input logic [31:0] addr);
    return {3'd4, 3'd0, 2'd2, 1'b0, addr, 4'hf, 32'h0, 1'b0};
  endfunction

  function automatic logic [DW-1:0] d_ack(input logic [31:0] data);
    return {3'd1, 2'd0, 2'd2, 1'b0, 1'b0, data, 1'b0};
  endfunction

  // Inputs are stable at the falling edge, so a handshake seen here fires on the next rising edge.
  always @(negedge clock) begin
    if (reset) begin
      if (in_a_valid && in_a_ready) a_q.push_back(in_a_bits);
      if (in_d_valid && in_d_ready) d_q.push_back(in_d_bits);
      if (out_a_valid && out_a_ready) begin
        vectors++;
        if (a_q.size() == 0) begin
          miscompares++;
          $display("FAIL a_order: got %h, scoreboard empty", out_a_bits);
        end else begin
          logic [AW-1:0] exp_a;
          exp_a = a_q.pop_front();
          if (out_a_bits !== exp_a) begin
            miscompares++;
            $display("FAIL a_order: got %h, expected %h", out_a_bits, exp_a);
          end
        end
      end
      if (out_d_valid && out_d_ready) begin
        vectors++;
        if (d_q.size() == 0) begin
          miscompares++;
          $display("FAIL d_order: got %h, scoreboard empty", out_d_bits);
        end else begin
          logic [DW-1:0] exp_d;
          exp_d = d_q.pop_front();
          if (out_d_bits !== exp_d) begin
            miscompares++;
            $display("FAIL d_order: got %h, expected %h", out_d_bits, exp_d);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset       = 1'b0;
    in_a_valid  = 1'b0;
    in_a_bits   = '0;
    out_a_ready = 1'b0;
    in_d_valid  = 1'b0;
    in_d_bits   = '0;
    out_d_ready = 1'b0;
    repeat (3) @(posedge clock);
    a_q.delete();
    d_q.delete();
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    step();
    vectors += 6;
    if (out_a_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_a_valid: got %b, expected 0", out_a_valid); end
    if (out_d_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_d_valid: got %b, expected 0", out_d_valid); end
    if (in_a_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_a_ready: got %b, expected 1", in_a_ready); end
    if (in_d_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_d_ready: got %b, expected 1", in_d_ready); end
    if (inflight !== 3'd0) begin miscompares++; $display("FAIL rst_inflight: got %0d, expected 0", inflight); end
    if (idle !== 1'b1) begin miscompares++; $display("FAIL rst_idle: got %b, expected 1", idle); end
  endtask

  task automatic test_a_backpressure();
    apply_reset();
    in_a_valid = 1'b1;
    in_a_bits  = a_get(32'h8000_0000);
    step();
    in_a_bits  = a_get(32'h8000_0004);
    step();
    in_a_bits  = a_get(32'h8000_0008);
    vectors += 3;
    if (in_a_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready_full: got %b, expected 0", in_a_ready); end
    if (out_a_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid_held: got %b, expected 1", out_a_valid); end
    if (out_a_bits !== a_get(32'h8000_0000)) begin miscompares++; $display("FAIL bp_head: got %h, expected %h", out_a_bits, a_get(32'h8000_0000)); end
    step();
    step();
    vectors++;
    if (out_a_bits !== a_get(32'h8000_0000)) begin miscompares++; $display("FAIL bp_head_stable: got %h, expected %h", out_a_bits, a_get(32'h8000_0000)); end
    out_a_ready = 1'b1;
    step();
    vectors += 2;
    if (in_a_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_back: got %b, expected 1", in_a_ready); end
    if (out_a_valid !== 1'b1) begin miscompares++; $display("FAIL bp_stream1: got %b, expected 1", out_a_valid); end
    step();
    in_a_valid = 1'b0;
    vectors += 2;
    if (out_a_valid !== 1'b1) begin miscompares++; $display("FAIL bp_stream2: got %b, expected 1", out_a_valid); end
    if (out_a_bits !== a_get(32'h8000_0008)) begin miscompares++; $display("FAIL bp_third: got %h, expected %h", out_a_bits, a_get(32'h8000_0008)); end
    step();
    vectors += 4;
    if (out_a_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drained: got %b, expected 0", out_a_valid); end
    if (inflight !== 3'd3) begin miscompares++; $display("FAIL bp_inflight: got %0d, expected 3", inflight); end
    if (idle !== 1'b0) begin miscompares++; $display("FAIL bp_idle: got %b, expected 0", idle); end
    if (a_q.size() != 0) begin miscompares++; $display("FAIL bp_leftover: got %0d, expected 0", a_q.size()); end
    out_a_ready = 1'b0;
  endtask

  task automatic test_inflight_limit();
    int accepted;
    apply_reset();
    accepted    = 0;
    out_a_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_a_valid = 1'b1;
      in_a_bits  = a_get(32'h9000_0000 + 32'(accepted * 4));
      if (in_a_ready) accepted++;
      step();
    end
    in_a_valid = 1'b0;
    step();
    step();
    vectors += 4;
    if (accepted != 4) begin miscompares++; $display("FAIL lim_accepted: got %0d, expected 4", accepted); end
    if (in_a_ready !== 1'b0) begin miscompares++; $display("FAIL lim_ready: got %b, expected 0", in_a_ready); end
    if (inflight !== 3'd4) begin miscompares++; $display("FAIL lim_inflight: got %0d, expected 4", inflight); end
    if (out_a_valid !== 1'b0) begin miscompares++; $display("FAIL lim_a_valid: got %b, expected 0", out_a_valid); end
    in_d_valid = 1'b1;
    in_d_bits  = d_ack(32'hDEAD_BEEF);
    step();
    in_d_valid = 1'b0;
    vectors += 3;
    if (out_d_valid !== 1'b1) begin miscompares++; $display("FAIL lim_d_valid: got %b, expected 1", out_d_valid); end
    if (out_d_bits !== d_ack(32'hDEAD_BEEF)) begin miscompares++; $display("FAIL lim_d_bits: got %h, expected %h", out_d_bits, d_ack(32'hDEAD_BEEF)); end
    if (inflight !== 3'd4) begin miscompares++; $display("FAIL lim_inflight_hold: got %0d, expected 4", inflight); end
    out_d_ready = 1'b1;
    step();
    out_d_ready = 1'b0;
    vectors += 4;
    if (inflight !== 3'd3) begin miscompares++; $display("FAIL lim_inflight_dec: got %0d, expected 3", inflight); end
    if (in_a_ready !== 1'b1) begin miscompares++; $display("FAIL lim_ready_back: got %b, expected 1", in_a_ready); end
    if (out_d_valid !== 1'b0) begin miscompares++; $display("FAIL lim_d_drained: got %b, expected 0", out_d_valid); end
    if (d_q.size() != 0) begin miscompares++; $display("FAIL lim_d_leftover: got %0d, expected 0", d_q.size()); end
  endtask

  task automatic test_d_wrap();
    apply_reset();
    in_d_valid = 1'b1;
    in_d_bits  = d_ack(32'd1);
    step();
    in_d_bits  = d_ack(32'd2);
    step();
    in_d_bits   = d_ack(32'd3);
    out_d_ready = 1'b1;
    vectors++;
    if (in_d_ready !== 1'b0) begin miscompares++; $display("FAIL wrap_full_ready: got %b, expected 0", in_d_ready); end
    step();
    for (int v = 3; v <= 6; v++) begin
      in_d_bits = d_ack(32'(v));
      vectors++;
      if (in_d_ready !== 1'b1) begin miscompares++; $display("FAIL wrap_stream_ready: beat %0d got %b, expected 1", v, in_d_ready); end
      step();
    end
    in_d_valid = 1'b0;
    vectors++;
    if (out_d_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_last_valid: got %b, expected 1", out_d_valid); end
    step();
    out_d_ready = 1'b0;
    vectors += 4;
    if (out_d_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_drained: got %b, expected 0", out_d_valid); end
    if (inflight !== 3'd0) begin miscompares++; $display("FAIL wrap_inflight_sat: got %0d, expected 0", inflight); end
    if (idle !== 1'b1) begin miscompares++; $display("FAIL wrap_idle: got %b, expected 1", idle); end
    if (d_q.size() != 0) begin miscompares++; $display("FAIL wrap_leftover: got %0d, expected 0", d_q.size()); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    in_a_valid = 1'b1;
    in_a_bits  = a_get(32'h8000_0100);
    step();
    in_a_valid  = 1'b0;
    out_a_ready = 1'b1;
    step();
    out_a_ready = 1'b0;
    in_a_valid  = 1'b1;
    in_a_bits   = a_get(32'h8000_0104);
    in_d_valid  = 1'b1;
    in_d_bits   = d_ack(32'h0000_0055);
    step();
    in_a_valid = 1'b0;
    in_d_valid = 1'b0;
    vectors += 3;
    if (out_a_valid !== 1'b1) begin miscompares++; $display("FAIL mid_pre_a: got %b, expected 1", out_a_valid); end
    if (out_d_valid !== 1'b1) begin miscompares++; $display("FAIL mid_pre_d: got %b, expected 1", out_d_valid); end
    if (inflight !== 3'd1) begin miscompares++; $display("FAIL mid_pre_inflight: got %0d, expected 1", inflight); end
    #2;
    reset = 1'b0;
    #1;
    vectors += 8;
    if (out_a_valid !== 1'b0) begin miscompares++; $display("FAIL mid_out_a_valid: got %b, expected 0", out_a_valid); end
    if (out_d_valid !== 1'b0) begin miscompares++; $display("FAIL mid_out_d_valid: got %b, expected 0", out_d_valid); end
    if (in_a_ready !== 1'b1) begin miscompares++; $display("FAIL mid_in_a_ready: got %b, expected 1", in_a_ready); end
    if (in_d_ready !== 1'b1) begin miscompares++; $display("FAIL mid_in_d_ready: got %b, expected 1", in_d_ready); end
    if (inflight !== 3'd0) begin miscompares++; $display("FAIL mid_inflight: got %0d, expected 0", inflight); end
    if (idle !== 1'b1) begin miscompares++; $display("FAIL mid_idle: got %b, expected 1", idle); end
    if (out_a_bits !== '0) begin miscompares++; $display("FAIL mid_a_bits: got %h, expected 0", out_a_bits); end
    if (out_d_bits !== '0) begin miscompares++; $display("FAIL mid_d_bits: got %h, expected 0", out_d_bits); end
    a_q.delete();
    d_q.delete();
    apply_reset();
  endtask

  task automatic test_flow_latency();
    apply_reset();
    out_a_ready = 1'b1;
    in_a_valid  = 1'b1;
    in_a_bits   = a_get(32'h8000_0200);
`ifdef TL_BUF_FLOW_EN
    vectors += 2;
    if (out_a_valid !== 1'b1) begin miscompares++; $display("FAIL flow_same_cycle_valid: got %b, expected 1", out_a_valid); end
    if (out_a_bits !== a_get(32'h8000_0200)) begin miscompares++; $display("FAIL flow_same_cycle_bits: got %h, expected %h", out_a_bits, a_get(32'h8000_0200)); end
    step();
    in_a_valid = 1'b0;
    vectors++;
    if (out_a_valid !== 1'b0) begin miscompares++; $display("FAIL flow_not_stored: got %b, expected 0", out_a_valid); end
`else
    vectors++;
    if (out_a_valid !== 1'b0) begin miscompares++; $display("FAIL reg_no_bypass: got %b, expected 0", out_a_valid); end
    step();
    in_a_valid = 1'b0;
    vectors += 2;
    if (out_a_valid !== 1'b1) begin miscompares++; $display("FAIL reg_one_cycle_valid: got %b, expected 1", out_a_valid); end
    if (out_a_bits !== a_get(32'h8000_0200)) begin miscompares++; $display("FAIL reg_one_cycle_bits: got %h, expected %h", out_a_bits, a_get(32'h8000_0200)); end
    step();
    vectors++;
    if (out_a_valid !== 1'b0) begin miscompares++; $display("FAIL reg_drained: got %b, expected 0", out_a_valid); end
`endif
    vectors += 2;
    if (inflight !== 3'd1) begin miscompares++; $display("FAIL lat_inflight: got %0d, expected 1", inflight); end
    if (a_q.size() != 0) begin miscompares++; $display("FAIL lat_leftover: got %0d, expected 0", a_q.size()); end
    out_a_ready = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_a_backpressure();
    test_inflight_limit();
    test_d_wrap();
    test_reset_mid();
    test_flow_latency();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tl_ul_channel_buffer.md
Name: tl_ul_channel_buffer

Overview:
- Registered TileLink-UL buffer between the core-side master port and the channel pass-through stage that drives the system bus.
- A channel (requests, master to slave) and D channel (responses, slave to master) each get an independent circular FIFO.
- Breaks combinational ready/valid paths in both directions.
- Tracks outstanding transactions and reports when the port is idle.

Parameters:
- A_DEPTH, 2: A-channel FIFO entries; power of two, minimum 2.
- D_DEPTH, 2: D-channel FIFO entries; power of two, minimum 2.
- SIZE_W, 2: width of the TileLink size field.
- SRC_W, 1: width of the source ID field.
- MAX_INFLIGHT, 4: outstanding-request limit; minimum 1.

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous active-low reset (0 = reset asserted)
- in_a_valid  in  1  upstream A valid
- in_a_ready  out  1  upstream A ready
- in_a_bits  in  AW  A payload; AW = 75+SIZE_W+SRC_W; fields MSB to LSB: opcode[3], param[3], size[SIZE_W], source[SRC_W], address[32], mask[4], data[32], corrupt[1]
- out_a_valid  out  1  downstream A valid
- out_a_ready  in  1  downstream A ready
- out_a_bits  out  AW  A payload to the downstream pass-through stage
- in_d_valid  in  1  downstream D valid
- in_d_ready  out  1  downstream D ready
- in_d_bits  in  DW  D payload; DW = 39+SIZE_W+SRC_W; fields MSB to LSB: opcode[3], param[2], size[SIZE_W], source[SRC_W], denied[1], data[32], corrupt[1]
- out_d_valid  out  1  upstream D valid
- out_d_ready  in  1  upstream D ready
- out_d_bits  out  DW  D payload to the master
- inflight  out  clog2(MAX_INFLIGHT+1)  number of outstanding requests
- idle  out  1  high when inflight==0 and both FIFOs are empty

Behaviour:
- Reset: all pointers, counts and storage clear to 0; all valid outputs 0; inflight 0; idle 1; in_a_ready 1; in_d_ready 1.
- Fire definition: a channel fires on a clock edge where its valid and ready are both high.
- FIFO structure: each FIFO has a wr_ptr, a rd_ptr (log2(DEPTH) bits, wrapping naturally at DEPTH-1 to 0) and a count of log2(DEPTH)+1 bits.
- out_x_valid = (count != 0).
- out_x_bits = storage[rd_ptr], registered. No combinational path from in_x_bits to out_x_bits unless TL_BUF_FLOW_EN is defined.
- in_d_ready = (count != D_DEPTH). It does not depend on out_d_ready.
- in_a_ready = (count != A_DEPTH) && (inflight_pending < MAX_INFLIGHT), where inflight_pending = inflight + A-FIFO count.
- The A-side request limit is a registered function: it uses only registered state.
- Enqueue and dequeue in the same cycle: count unchanged and both pointers advance. When the FIFO is full, enqueue is already blocked by ready.
- Latency without flow: 1 cycle minimum from input fire to output valid.
- Throughput: one beat per cycle sustained per channel.
- inflight counter:
  - +1 on out_a fire.
  - -1 on out_d fire.
  - Unchanged when both occur in the same cycle.
  - Saturates at 0 on underflow; no wrap. A D response with inflight==0 is a protocol error and is still forwarded.
- Payload handling: carried opaquely; no field is decoded. Single-beat UL only: every D beat decrements inflight.
- Reset asserted mid-transfer: contents are discarded; outputs return to their reset values asynchronously.

Optional Feature:
- Macro: TL_BUF_FLOW_EN.
- Defined, when a FIFO is empty and in_x_valid is high:
  - out_x_valid = 1 and out_x_bits = in_x_bits in the same cycle.
  - If out_x_ready is also high, the beat passes through without being written.
  - Otherwise the beat is enqueued as normal.
  - in_x_ready is unchanged (still registered).
- Not defined: strict registered behaviour, 1-cycle minimum latency.

Test Plan:
- Reset with reset=0 held for 3 cycles, then released -> out_a_valid=0, out_d_valid=0, in_a_ready=1, in_d_ready=1, inflight=0, idle=1.
- Three A Get beats (address 0x8000_0000, 0x8000_0004, 0x8000_0008) with out_a_ready=0 -> in_a_ready falls after 2 beats; first beat stays held.
  - Then set out_a_ready=1 -> beats emerge in order, one per cycle; inflight reaches 3.
- Continuous A traffic with out_a_ready=1 and no D responses, MAX_INFLIGHT=4 -> exactly 4 requests accepted, then in_a_ready=0.
  - One D AccessAck with data 0xDEAD_BEEF, out_d_ready=1 -> D beat forwarded with identical bits; inflight drops to 3; in_a_ready returns to 1.
- D FIFO full (2 beats) while enqueue and out_d_ready are raised in the same cycle -> in_d_ready=0 that cycle; count stays 2.
  - Next cycle: one dequeue and one enqueue per cycle; ordering preserved across pointer wrap (6 beats, data 1..6).
- Reset asserted with 1 beat in each FIFO and inflight=1 -> all outputs return to reset values immediately without waiting for a clock edge.
- With TL_BUF_FLOW_EN, FIFO empty, in_a_valid=1 and out_a_ready=1 -> out_a_bits equals in_a_bits in the same cycle and the FIFO count stays 0.
  - Without the macro, the same stimulus -> out_a_valid rises one cycle later.
